nexys_starship_spawn_gen: RTL and testbench
===========================================

Name: nexys_starship_spawn_gen

Overview:
Upstream monster-spawn scheduler for the four lane monster state machines (top, bottom, left, right). It runs on timer_clk and uses a 16-bit Galois LFSR plus a difficulty ramp to issue one-cycle, one-hot spawn requests (top_random etc.). A request goes only to a lane whose monster SM is not FULL, and consecutive requests obey a minimum gap. Spawn activity is gated by play_flag and gameover.

Parameters:
LFSR_SEED, 16'hACE1, LFSR load value on reset; a value of 0 is replaced by 16'h0001
MIN_GAP, 2, minimum number of no-spawn RUN cycles between spawn pulses (range 0-15)
INIT_THRESH, 9'd40, spawn probability threshold on entering RUN (out of 256)
THRESH_STEP, 9'd8, threshold increment per ramp period
THRESH_MAX, 9'd200, threshold saturation value (≤ 256; 256 means spawn whenever eligible)
RAMP_PERIOD, 16, RUN cycles per difficulty step (≥ 1)

Ports:
timer_clk  in  1  game tick clock
Reset  in  1  asynchronous, active-high reset
play_flag  in  1  game active from the home screen
gameover  in  1  any lane reports game over
occupied  in  4  lane is FULL; [0] top, [1] bottom, [2] left, [3] right
spawn  out  4  one-hot spawn request, registered, high for one cycle
top_random  out  1  spawn[0]
btm_random  out  1  spawn[1]
left_random  out  1  spawn[2]
right_random  out  1  spawn[3]
level  out  4  difficulty level, saturates at 15
spawn_count  out  8  total spawns this game, saturates at 255
q_Idle, q_Run, q_Halt  out  1 each  one-hot state outputs

Behaviour:
- Reset (async): state IDLE; lfsr = seed; spawn=0; level=0; spawn_count=0; thresh=INIT_THRESH; gap_cnt=0; ramp_cnt=0.
- LFSR: advances on every timer_clk edge in all states when Reset is low: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- IDLE: spawn=0; thresh, level, spawn_count, gap_cnt and ramp_cnt are reloaded to their reset values. If play_flag=1 and gameover=0, go to RUN.
- RUN, evaluated each edge:
  - gameover=1: go to HALT, spawn=0. Gameover beats a simultaneous eligible spawn.
  - Otherwise gap_cnt increments and saturates at MIN_GAP. A spawn is eligible when gap_cnt==MIN_GAP and {1'b0,lfsr[7:0]} < thresh, both read from pre-edge register values.
  - Lane choice: candidate lane L = lfsr[9:8]. Take the first unoccupied lane in order L, L+1, L+2, L+3 (mod 4). If all four lanes are occupied, there is no spawn and gap_cnt is unchanged.
  - On a spawn, the spawn register receives that lane's one-hot bit, gap_cnt <= 0, and spawn_count increments, saturating at 255. Otherwise spawn <= 0.
  - ramp_cnt increments. When ramp_cnt==RAMP_PERIOD-1, ramp_cnt wraps to 0, thresh <= min(thresh+THRESH_STEP, THRESH_MAX) using 10-bit intermediate arithmetic, and level increments, saturating at 15.
- Latency: a spawn decision made at edge N is visible on spawn for exactly the cycle after edge N. spawn is never high for two consecutive cycles when MIN_GAP ≥ 1.
- HALT: spawn=0. level, spawn_count and thresh are held. Go to IDLE when play_flag=0.
- Invalid state encoding: go to IDLE on the next edge with spawn=0.
- Reset mid-operation clears spawn immediately, without waiting for a clock edge.

Test Plan:
1. Assert Reset, then release -> spawn=0, q_Idle=1, lfsr=16'hACE1. After one edge lfsr=16'hE270.
2. INIT_THRESH=256, MIN_GAP=2, occupied=0, raise play_flag -> after entering RUN, spawn pulses every 3rd cycle. Each pulse is one-hot on lane lfsr[9:8] of the decision cycle, and spawn_count counts 1, 2, 3 and so on.
3. INIT_THRESH=256 with occupied=4'b1111 -> spawn stays 0 indefinitely. With occupied=4'b1110 -> every pulse is spawn=4'b0001 (top_random).
4. INIT_THRESH=0, THRESH_STEP=8, THRESH_MAX=16, RAMP_PERIOD=4 -> no spawns during the first 4 RUN cycles. Then thresh=8 and level=1, then thresh=16 and level=2, then thresh stays at 16 while level continues to 15 and holds there.
5. Raise gameover on a cycle where a spawn is eligible -> no pulse, q_Halt=1, spawn_count is held. Drop play_flag -> q_Idle=1 and thresh=INIT_THRESH. Raise play_flag again -> spawn_count restarts from 0.
6. Assert Reset mid-RUN while spawn=4'b0100 -> spawn=0 and q_Idle=1 before the next timer_clk edge.

Source files
------------

// File: rtl/nexys_starship_spawn_gen.sv
`default_nettype none
// ============================================================================
// Module   : nexys_starship_spawn_gen
// Purpose  : LFSR-driven, difficulty-ramped one-hot monster spawn scheduler
// Revision : 1.0 - initial release
// ============================================================================
module nexys_starship_spawn_gen #(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned MIN_GAP     = 2,
    parameter logic [8:0]  INIT_THRESH = 9'd40,
    parameter logic [8:0]  THRESH_STEP = 9'd8,
    parameter logic [8:0]  THRESH_MAX  = 9'd200,
    parameter int unsigned RAMP_PERIOD = 16
) (
    input  logic       timer_clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover,
    input  logic [3:0] occupied,
    output logic [3:0] spawn,
    output logic       top_random,
    output logic       btm_random,
    output logic       left_random,
    output logic       right_random,
    output logic [3:0] level,
    output logic [7:0] spawn_count,
    output logic       q_Idle,
    output logic       q_Run,
    output logic       q_Halt
);

    localparam logic [15:0] c_SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [3:0]  c_MIN_GAP   = 4'(MIN_GAP);
    localparam logic [15:0] c_RAMP_LAST = 16'(RAMP_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [3:0]  r_spawn;
    logic [3:0]  r_level;
    logic [7:0]  r_count;
    logic [8:0]  r_thresh;
    logic [3:0]  r_gap;
    logic [15:0] r_ramp;

    logic [15:0] w_lfsr_next;
    logic [1:0]  w_cand;
    logic [1:0]  w_lane;
    logic        w_any_free;
    logic        w_fire;
    logic [3:0]  w_onehot;
    logic [9:0]  w_thresh_sum;
    logic [8:0]  w_thresh_next;

    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_cand      = r_lfsr[9:8];

    // Scan offsets high to low so the nearest free lane from the candidate wins.
    always_comb begin
        w_lane     = w_cand;
        w_any_free = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!occupied[w_cand + 2'(i)]) begin
                w_lane     = w_cand + 2'(i);
                w_any_free = 1'b1;
            end
        end
    end

    assign w_onehot      = 4'b0001 << w_lane;
    assign w_fire        = (r_gap == c_MIN_GAP) && ({1'b0, r_lfsr[7:0]} < r_thresh) && w_any_free;
    assign w_thresh_sum  = {1'b0, r_thresh} + {1'b0, THRESH_STEP};
    assign w_thresh_next = (w_thresh_sum > {1'b0, THRESH_MAX}) ? THRESH_MAX : w_thresh_sum[8:0];

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_lfsr   <= c_SEED;
            r_spawn  <= 4'b0000;
            r_level  <= 4'd0;
            r_count  <= 8'd0;
            r_thresh <= INIT_THRESH;
            r_gap    <= 4'd0;
            r_ramp   <= 16'd0;
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_IDLE: begin
                    r_spawn  <= 4'b0000;
                    r_level  <= 4'd0;
                    r_count  <= 8'd0;
                    r_thresh <= INIT_THRESH;
                    r_gap    <= 4'd0;
                    r_ramp   <= 16'd0;
                    if (play_flag && !gameover) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (gameover) begin
                        r_state <= S_HALT;
                        r_spawn <= 4'b0000;
                    end else begin
                        if (w_fire) begin
                            r_spawn <= w_onehot;
                            r_gap   <= 4'd0;
                            if (r_count != 8'd255) begin
                                r_count <= r_count + 8'd1;
                            end
                        end else begin
                            r_spawn <= 4'b0000;
                            if (r_gap != c_MIN_GAP) begin
                                r_gap <= r_gap + 4'd1;
                            end
                        end
                        if (r_ramp == c_RAMP_LAST) begin
                            r_ramp   <= 16'd0;
                            r_thresh <= w_thresh_next;
                            if (r_level != 4'd15) begin
                                r_level <= r_level + 4'd1;
                            end
                        end else begin
                            r_ramp <= r_ramp + 16'd1;
                        end
                    end
                end
                S_HALT: begin
                    r_spawn <= 4'b0000;
                    if (!play_flag) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_spawn <= 4'b0000;
                end
            endcase
        end
    end

    assign spawn        = r_spawn;
    assign top_random   = r_spawn[0];
    assign btm_random   = r_spawn[1];
    assign left_random  = r_spawn[2];
    assign right_random = r_spawn[3];
    assign level        = r_level;
    assign spawn_count  = r_count;
    assign q_Idle       = (r_state == S_IDLE);
    assign q_Run        = (r_state == S_RUN);
    assign q_Halt       = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_nexys_starship_spawn_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_nexys_starship_spawn_gen
// Purpose  : Directed self-checking bench for the spawn scheduler
// Revision : 1.0 - initial release
// ============================================================================
module tb_nexys_starship_spawn_gen;

    logic       timer_clk = 1'b0;
    logic       Reset     = 1'b1;

    logic       a_play = 1'b0, a_gameover = 1'b0;
    logic [3:0] a_occupied = 4'b0000;
    logic [3:0] a_spawn, a_level;
    logic       a_top, a_btm, a_left, a_right;
    logic [7:0] a_count;
    logic       a_idle, a_run, a_halt;

    logic       b_play = 1'b0, b_gameover = 1'b0;
    logic [3:0] b_spawn, b_level;
    logic       b_top, b_btm, b_left, b_right;
    logic [7:0] b_count;
    logic       b_idle, b_run, b_halt;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [15:0] m_lfsr;

    always #5 timer_clk = ~timer_clk;

    // Always-eligible instance: threshold pinned at 256.
    nexys_starship_spawn_gen #(
        .INIT_THRESH(9'd256), .THRESH_MAX(9'd256), .MIN_GAP(2)
    ) u_dut_a (
        .timer_clk(timer_clk), .Reset(Reset), .play_flag(a_play), .gameover(a_gameover),
        .occupied(a_occupied), .spawn(a_spawn), .top_random(a_top), .btm_random(a_btm),
        .left_random(a_left), .right_random(a_right), .level(a_level), .spawn_count(a_count),
        .q_Idle(a_idle), .q_Run(a_run), .q_Halt(a_halt)
    );

    // Ramp instance: thresh 0 -> 8 -> 16, four RUN cycles per step.
    nexys_starship_spawn_gen #(
        .INIT_THRESH(9'd0), .THRESH_STEP(9'd8), .THRESH_MAX(9'd16), .RAMP_PERIOD(4)
    ) u_dut_b (
        .timer_clk(timer_clk), .Reset(Reset), .play_flag(b_play), .gameover(b_gameover),
        .occupied(4'b0000), .spawn(b_spawn), .top_random(b_top), .btm_random(b_btm),
        .left_random(b_left), .right_random(b_right), .level(b_level), .spawn_count(b_count),
        .q_Idle(b_idle), .q_Run(b_run), .q_Halt(b_halt)
    );

    always @(posedge timer_clk or posedge Reset) begin
        if (Reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic tick();
        @(posedge timer_clk);
        @(negedge timer_clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge timer_clk);
        n_cmp++; if (a_spawn !== 4'b0000) begin n_err++; $display("FAIL reset_spawn: got %b want 0000", a_spawn); end
        n_cmp++; if (a_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", a_idle); end
        n_cmp++; if (u_dut_a.r_lfsr !== 16'hACE1) begin n_err++; $display("FAIL reset_lfsr: got %h want ace1", u_dut_a.r_lfsr); end
        Reset = 1'b0;
        n_cmp++; if (a_count !== 8'd0 || a_level !== 4'd0) begin n_err++; $display("FAIL reset_cnt_lvl: got %0d/%0d want 0/0", a_count, a_level); end
        n_cmp++; if (u_dut_b.r_thresh !== 9'd0) begin n_err++; $display("FAIL reset_thresh_b: got %0d want 0", u_dut_b.r_thresh); end
        tick();
        n_cmp++; if (u_dut_a.r_lfsr !== 16'hE270) begin n_err++; $display("FAIL lfsr_step1: got %h want e270", u_dut_a.r_lfsr); end
        n_cmp++; if (a_idle !== 1'b1) begin n_err++; $display("FAIL idle_hold: got %b want 1", a_idle); end
    endtask

    task automatic test_periodic();
        logic [1:0] lane;
        logic [3:0] exp_sp;
        logic [7:0] exp_cnt = 8'd0;
        a_play = 1'b1;
        tick();
        n_cmp++; if (a_run !== 1'b1) begin n_err++; $display("FAIL enter_run: got %b want 1", a_run); end
        for (int k = 1; k <= 12; k++) begin
            lane = m_lfsr[9:8];
            tick();
            if (k % 3 == 0) begin
                exp_sp = 4'b0001 << lane;
                exp_cnt++;
            end else begin
                exp_sp = 4'b0000;
            end
            n_cmp++; if (a_spawn !== exp_sp) begin n_err++; $display("FAIL periodic_spawn k=%0d: got %b want %b", k, a_spawn, exp_sp); end
            n_cmp++; if ({a_right, a_left, a_btm, a_top} !== exp_sp) begin n_err++; $display("FAIL lane_outputs k=%0d: got %b want %b", k, {a_right, a_left, a_btm, a_top}, exp_sp); end
            n_cmp++; if (a_count !== exp_cnt) begin n_err++; $display("FAIL periodic_count k=%0d: got %0d want %0d", k, a_count, exp_cnt); end
        end
    endtask

    task automatic test_gameover();
        repeat (2) begin
            tick();
            n_cmp++; if (a_spawn !== 4'b0000) begin n_err++; $display("FAIL pre_gameover_gap: got %b want 0000", a_spawn); end
        end
        a_gameover = 1'b1;
        tick();
        n_cmp++; if (a_spawn !== 4'b0000) begin n_err++; $display("FAIL gameover_spawn: got %b want 0000", a_spawn); end
        n_cmp++; if (a_halt !== 1'b1) begin n_err++; $display("FAIL gameover_halt: got %b want 1", a_halt); end
        n_cmp++; if (a_count !== 8'd4) begin n_err++; $display("FAIL gameover_count: got %0d want 4", a_count); end
        a_play = 1'b0;
        a_gameover = 1'b0;
        tick();
        n_cmp++; if (a_idle !== 1'b1) begin n_err++; $display("FAIL halt_to_idle: got %b want 1", a_idle); end
        tick();
        n_cmp++; if (a_count !== 8'd0) begin n_err++; $display("FAIL idle_count_clear: got %0d want 0", a_count); end
        n_cmp++; if (u_dut_a.r_thresh !== 9'd256) begin n_err++; $display("FAIL idle_thresh: got %0d want 256", u_dut_a.r_thresh); end
        a_play = 1'b1;
        tick();
        n_cmp++; if (a_run !== 1'b1 || a_count !== 8'd0) begin n_err++; $display("FAIL restart: got run=%b cnt=%0d want 1/0", a_run, a_count); end
    endtask

    task automatic test_occupancy();
        int pulses = 0;
        a_occupied = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++; if (a_spawn !== 4'b0000) begin n_err++; $display("FAIL all_full k=%0d: got %b want 0000", k, a_spawn); end
        end
        a_occupied = 4'b1110;
        for (int j = 1; j <= 9; j++) begin
            tick();
            n_cmp++;
            if (j % 3 == 1) begin
                if (a_spawn !== 4'b0001) begin n_err++; $display("FAIL top_only j=%0d: got %b want 0001", j, a_spawn); end
            end else begin
                if (a_spawn !== 4'b0000) begin n_err++; $display("FAIL top_only_gap j=%0d: got %b want 0000", j, a_spawn); end
            end
            if (a_top) pulses++;
        end
        n_cmp++; if (pulses != 3 || a_count !== 8'd3) begin n_err++; $display("FAIL top_only_count: got %0d/%0d want 3/3", pulses, a_count); end
    endtask

    task automatic test_reset_midrun();
        a_occupied = 4'b1011;
        tick();
        n_cmp++; if (a_spawn !== 4'b0100) begin n_err++; $display("FAIL left_wrap: got %b want 0100", a_spawn); end
        #1 Reset = 1'b1;
        #1;
        n_cmp++; if (a_spawn !== 4'b0000) begin n_err++; $display("FAIL async_spawn: got %b want 0000", a_spawn); end
        n_cmp++; if (a_idle !== 1'b1) begin n_err++; $display("FAIL async_idle: got %b want 1", a_idle); end
        n_cmp++; if (a_count !== 8'd0) begin n_err++; $display("FAIL async_count: got %0d want 0", a_count); end
        @(negedge timer_clk);
        n_cmp++; if (u_dut_a.r_lfsr !== 16'hACE1) begin n_err++; $display("FAIL reset_lfsr_hold: got %h want ace1", u_dut_a.r_lfsr); end
        Reset = 1'b0;
    endtask

    task automatic test_lane_order();
        logic [1:0] lane;
        logic [1:0] exp_lane;
        logic [3:0] exp_sp;
        a_occupied = 4'b0101;
        tick();
        for (int k = 1; k <= 9; k++) begin
            lane = m_lfsr[9:8];
            tick();
            // Free lanes are 1 and 3 only.
            case (lane)
                2'd0, 2'd1: exp_lane = 2'd1;
                default:    exp_lane = 2'd3;
            endcase
            exp_sp = (k % 3 == 0) ? (4'b0001 << exp_lane) : 4'b0000;
            n_cmp++; if (a_spawn !== exp_sp) begin n_err++; $display("FAIL lane_order k=%0d: got %b want %b", k, a_spawn, exp_sp); end
        end
    endtask

    task automatic test_ramp();
        int q;
        logic [3:0] exp_lvl;
        logic [8:0] exp_th;
        b_play = 1'b1;
        tick();
        for (int k = 1; k <= 68; k++) begin
            tick();
            q = k / 4;
            exp_lvl = (q > 15) ? 4'd15 : 4'(q);
            exp_th  = (q >= 2) ? 9'd16 : 9'(8 * q);
            if (k <= 4) begin
                n_cmp++; if (b_spawn !== 4'b0000) begin n_err++; $display("FAIL ramp_nospawn k=%0d: got %b want 0000", k, b_spawn); end
            end
            n_cmp++; if (b_level !== exp_lvl) begin n_err++; $display("FAIL ramp_level k=%0d: got %0d want %0d", k, b_level, exp_lvl); end
            n_cmp++; if (u_dut_b.r_thresh !== exp_th) begin n_err++; $display("FAIL ramp_thresh k=%0d: got %0d want %0d", k, u_dut_b.r_thresh, exp_th); end
        end
        b_gameover = 1'b1;
        tick();
        n_cmp++; if (b_halt !== 1'b1 || b_level !== 4'd15) begin n_err++; $display("FAIL ramp_halt: got halt=%b lvl=%0d want 1/15", b_halt, b_level); end
        b_play = 1'b0;
        b_gameover = 1'b0;
        repeat (2) tick();
        n_cmp++; if (b_idle !== 1'b1 || u_dut_b.r_thresh !== 9'd0 || b_level !== 4'd0) begin
            n_err++; $display("FAIL ramp_idle_reload: got idle=%b th=%0d lvl=%0d want 1/0/0", b_idle, u_dut_b.r_thresh, b_level);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_gameover();
        test_occupancy();
        test_reset_midrun();
        test_lane_order();
        test_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
